// File: rtl/seq_pattern_gen.sv
// Programmable serial bit-pattern transmitter: captures a pattern, length, repeat
// count and gap on start, then shifts the pattern out MSB-first with registered outputs.
module seq_pattern_gen #(
    parameter int P_WIDTH = 8,
    parameter int P_LENW  = 4,
    parameter int P_REPW  = 4,
    parameter int P_GAPW  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [P_WIDTH-1:0] i_pattern,
    input  logic [P_LENW-1:0]  i_len,
    input  logic [P_REPW-1:0]  i_repeat,
    input  logic [P_GAPW-1:0]  i_gap,
    output logic               o_seq,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [P_LENW-1:0]  LEN_MAX = P_LENW'(P_WIDTH);
    localparam logic [P_LENW-1:0]  LEN_ONE = P_LENW'(1);
    localparam logic [P_REPW:0]    REP_ONE = (P_REPW+1)'(1);
    localparam logic [P_GAPW-1:0]  GAP_ONE = P_GAPW'(1);
    localparam logic [P_WIDTH-1:0] BIT_ONE = P_WIDTH'(1);

    state_t               state_q, state_d;
    logic [P_WIDTH-1:0]   pat_q, pat_d;
    logic [P_LENW-1:0]    len_q, len_d;
    logic [P_GAPW-1:0]    gap_len_q, gap_len_d;
    logic [P_LENW-1:0]    idx_q, idx_d;
    logic [P_REPW:0]      rep_q, rep_d;
    logic [P_GAPW-1:0]    gap_cnt_q, gap_cnt_d;

    logic                 start_ok;
    logic [P_LENW-1:0]    len_clamped;
    logic [P_WIDTH-1:0]   bit_mask;
    logic                 seq_d, valid_d, busy_d, done_d;

    // Zero or oversize lengths mean "the whole pattern register".
    always_comb begin
        len_clamped = i_len;
        if (i_len == '0 || i_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    assign start_ok = i_start && !i_abort;

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        gap_len_d = gap_len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    pat_d     = i_pattern;
                    len_d     = len_clamped;
                    gap_len_d = i_gap;
                    idx_d     = len_clamped - LEN_ONE;
                    rep_d     = {1'b0, i_repeat} + REP_ONE;
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - LEN_ONE;
                end else if (rep_q > REP_ONE) begin
                    rep_d = rep_q - REP_ONE;
                    if (gap_len_q == '0) begin
                        idx_d = len_q - LEN_ONE;
                    end else begin
                        gap_cnt_d = gap_len_q;
                        state_d   = ST_GAP;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_GAP: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == GAP_ONE) begin
                    idx_d   = len_q - LEN_ONE;
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change only
    // on the clock edge and line up with the state they describe.
    always_comb begin
        bit_mask = BIT_ONE << idx_d;
        seq_d    = (state_d == ST_SEND) && |(pat_d & bit_mask);
        valid_d  = (state_d == ST_SEND);
        busy_d   = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            gap_len_q <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            o_seq     <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            gap_len_q <= gap_len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_cnt_q <= gap_cnt_d;
            o_seq     <= seq_d;
            o_valid   <= valid_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
        end
    end

endmodule
